// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Brief    : Shared types, default sizes and the burst-length clamp used by
//            the async-FIFO read-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  localparam int c_NUM_REQ_DEF   = 4;
  localparam int c_MAX_BURST_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // A zero request still moves one word; anything over the ceiling is cut to it.
  function automatic int unsigned clamp_burst(input int unsigned len,
                                              input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector. Returns the first active
//            request at or above rr_ptr, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = c_NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               valid,
  output logic [ID_W-1:0]    index,
  output logic [NUM_REQ-1:0] onehot
);

  // Walk NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    logic [ID_W-1:0] w_pos;
    w_pos  = '0;
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!valid && req[w_pos]) begin
        valid         = 1'b1;
        index         = w_pos;
        onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Brief    : Read-domain arbiter sharing the async FIFO read port among
//            NUM_REQ consumers in round-robin bursts; every returned word is
//            tagged with the owning consumer ID.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = c_NUM_REQ_DEF,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = c_MAX_BURST_DEF,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int BL_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [BL_W-1:0]       burst_len,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ID_W-1:0]       dout_id,
  output logic                  burst_done
);

  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [BL_W-1:0]    r_len;
  logic [BL_W-1:0]    r_count;
  logic [BL_W-1:0]    w_count_inc;
  logic [BL_W-1:0]    w_len_clamped;
  logic [NUM_REQ-1:0] r_gnt;
  logic               w_pick_valid;
  logic [ID_W-1:0]    w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic               w_take;
  logic               w_rinc;
  logic               w_last;
  logic               w_exit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .index  (w_pick_idx),
    .onehot (w_pick_onehot)
  );

  assign w_len_clamped = BL_W'(clamp_burst(32'(burst_len), MAX_BURST));
  assign w_count_inc   = r_count + BL_W'(1);

  // Next-state and read-increment decode; the last word of a full burst and an
  // owner dropping its request both leave BURST on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_rinc      = 1'b0;
    w_last      = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid && !rempty) begin
          w_take      = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_rinc = !rempty && req[r_owner] && (r_count < r_len);
        w_last = w_rinc && (w_count_inc == r_len);
        if (w_last || !req[r_owner] || (r_count >= r_len)) begin
          w_exit      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst bookkeeping: owner/length latch at grant, count, round-robin pointer.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_owner  <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
    end else if (w_take) begin
      r_owner <= w_pick_idx;
      r_len   <= w_len_clamped;
      r_count <= '0;
      r_gnt   <= w_pick_onehot;
    end else begin
      if (w_rinc) begin
        r_count <= w_count_inc;
      end
      if (w_exit) begin
        r_gnt    <= '0;
        r_rr_ptr <= (r_owner == c_LAST_ID) ? '0 : r_owner + ID_W'(1);
      end
    end
  end

  // Output word register: captures the memory word on each read increment.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      dout       <= '0;
      dout_id    <= '0;
      dout_valid <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      dout_valid <= w_rinc;
      burst_done <= w_last;
      if (w_rinc) begin
        dout    <= rdata;
        dout_id <= r_owner;
      end
    end
  end

  assign rinc = w_rinc;
  assign gnt  = r_gnt;
  assign busy = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Brief    : Directed self-checking bench for fifo_rd_arbiter with a small
//            behavioural FIFO read port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] burst_len = '0;
  logic       stall = 1'b0;
  logic       mon_en = 1'b0;

  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] dout_id;
  logic       burst_done;

  logic [7:0]  mem [0:63];
  logic [31:0] rd_ptr = '0;
  logic [31:0] wr_cnt = '0;

  logic [15:0] vq [$];
  logic [31:0] trace = '0;
  int          done_cnt = 0;
  int          viol = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  fifo_rd_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (8)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .req        (req),
    .burst_len  (burst_len),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .gnt        (gnt),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_id    (dout_id),
    .burst_done (burst_done)
  );

  always #5 rclk = ~rclk;

  // FIFO read side: empty when all loaded words are consumed or when forced.
  assign rempty = (rd_ptr == wr_cnt) || stall;
  assign rdata  = mem[rd_ptr[5:0]];

  always @(posedge rclk) begin
    if (rinc === 1'b1 && !rempty) rd_ptr <= rd_ptr + 1;
  end

  // Mid-cycle observer: output words, done pulses, rinc history, invariants.
  always @(negedge rclk) begin
    trace = {trace[30:0], (rinc === 1'b1)};
    if (dout_valid === 1'b1) vq.push_back({6'b0, dout_id, dout});
    if (burst_done === 1'b1) done_cnt++;
    if (mon_en) begin
      if (rinc === 1'b1 && (rempty || busy !== 1'b1)) viol++;
      if (!$onehot0(gnt)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) mem[6'(rd_ptr + 32'(i))] = base + 8'(i);
    wr_cnt = rd_ptr + 32'(n);
  endtask

  task automatic do_reset();
    rrst  = 1'b1;
    req   = '0;
    stall = 1'b0;
    tick(1);
    rrst  = 1'b0;
    vq.delete();
    done_cnt = 0;
  endtask

  // Expected word i: data base+i, owner id0 advancing every per_id words.
  task automatic chk_words(input string tag, input int n, input logic [7:0] base,
                           input int id0, input int per_id);
    logic [1:0] e_id;
    chk({tag, "_cnt"}, vq.size(), n);
    for (int i = 0; i < n && i < vq.size(); i++) begin
      e_id = 2'((id0 + ((per_id == 0) ? 0 : i / per_id)) % 4);
      chk(tag, {16'b0, vq[i]}, {16'b0, 6'b0, e_id, base + 8'(i)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rrst = 1'b1;
    tick(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dvalid", dout_valid, 0);
    chk("rst_did", dout_id, 0);
    chk("rst_done", burst_done, 0);
    rrst = 1'b0;
    mon_en = 1'b1;

    // Single requester, 10 words, bursts of 4
    do_reset();
    load(8'hA0, 10);
    burst_len = 4'd4;
    req = 4'b0001;
    tick(1);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_busy", busy, 1);
    tick(4);
    chk("t1_bubble_busy", busy, 0);
    chk("t1_bubble_gnt", gnt, 0);
    tick(9);
    chk("t1_rinc_trace", trace[13:0], 14'b01111011110110);
    req = 4'b0000;
    tick(2);
    chk("t1_done", done_cnt, 2);
    chk_words("t1_word", 10, 8'hA0, 0, 0);

    // Round robin, all four requesting, bursts of 2
    do_reset();
    load(8'hB0, 16);
    burst_len = 4'd2;
    req = 4'b1111;
    tick(15);
    req = 4'b0000;
    tick(2);
    chk("t2_done", done_cnt, 5);
    chk_words("t2_word", 10, 8'hB0, 0, 2);

    // Empty stall for three cycles after two reads
    do_reset();
    load(8'hC0, 16);
    burst_len = 4'd5;
    req = 4'b0001;
    tick(3);
    stall = 1'b1;
    tick(1);
    chk("t3_stall_gnt", gnt, 4'b0001);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_rinc", rinc, 0);
    tick(2);
    stall = 1'b0;
    tick(3);
    req = 4'b0000;
    tick(1);
    chk("t3_rinc_trace", trace[9:0], 10'b0110001110);
    tick(2);
    chk("t3_done", done_cnt, 1);
    chk_words("t3_word", 5, 8'hC0, 0, 0);

    // Early release by requester 2 after 3 of 8 reads
    do_reset();
    load(8'hD0, 16);
    burst_len = 4'd8;
    req = 4'b0100;
    tick(1);
    chk("t4_gnt2", gnt, 4'b0100);
    tick(3);
    req = 4'b1001;
    tick(2);
    chk("t4_next_gnt", gnt, 4'b1000);
    chk("t4_next_busy", busy, 1);
    req = 4'b0000;
    tick(3);
    chk("t4_done", done_cnt, 0);
    chk_words("t4_word", 3, 8'hD0, 2, 0);

    // Clamp: zero length gives single-word bursts
    do_reset();
    load(8'hE0, 16);
    burst_len = 4'd0;
    req = 4'b0001;
    tick(6);
    req = 4'b0000;
    chk("t5a_rinc_trace", trace[5:0], 6'b010101);
    tick(2);
    chk("t5a_done", done_cnt, 3);
    chk_words("t5a_word", 3, 8'hE0, 0, 0);

    // Clamp: 15 cut to MAX_BURST; mid-burst length change ignored
    do_reset();
    load(8'h10, 20);
    burst_len = 4'd15;
    req = 4'b0001;
    tick(3);
    burst_len = 4'd1;
    tick(6);
    req = 4'b0000;
    tick(1);
    chk("t5b_rinc_trace", trace[9:0], 10'b0111111110);
    tick(2);
    chk("t5b_done", done_cnt, 1);
    chk_words("t5b_word", 8, 8'h10, 0, 0);

    // Reset during read 2 of requester 1's burst
    do_reset();
    load(8'h60, 16);
    burst_len = 4'd4;
    req = 4'b0011;
    tick(7);
    chk("t6_pre_rinc", rinc, 1);
    chk("t6_pre_gnt", gnt, 4'b0010);
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    chk("t6_gnt", gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rinc", rinc, 0);
    chk("t6_dvalid", dout_valid, 0);
    chk("t6_dout", dout, 0);
    chk("t6_did", dout_id, 0);
    tick(1);
    chk("t6_restart_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick(3);

    chk("invariants", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
